// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clk to a pixel rate, scans H/V counters and produces
// registered sync, blanking and line/frame pulses aligned with the x/y outputs.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [9:0] HMax  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMax  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis  = 10'(H_VIS);
  localparam logic [9:0] VVis  = 10'(V_VIS);
  localparam logic [9:0] HsBeg = 10'(H_VIS + H_FP);
  localparam logic [9:0] HsEnd = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsBeg = 10'(V_VIS + V_FP);
  localparam logic [9:0] VsEnd = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d, v_q, v_d;
  logic            tick, h_wrap, v_wrap;
  logic            pix_tick_q, video_on_q, hsync_q, vsync_q, line_start_q, frame_start_q;

  // The tick is sampled from the divider phase, so the first pixel step lands CLK_DIV clks
  // after reset release and counters/outputs update on that same edge.
  always_comb begin
    tick   = (div_q == DivMax);
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (tick) begin
      if (h_q == HMax) begin
        h_d    = '0;
        h_wrap = 1'b1;
        if (v_q == VMax) begin
          v_d    = '0;
          v_wrap = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      pix_tick_q    <= 1'b0;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pix_tick_q    <= tick;
      video_on_q    <= (h_d < HVis) && (v_d < VVis);
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
      hsync_q       <= ((h_d >= HsBeg) && (h_d <= HsEnd)) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= ((v_d >= VsBeg) && (v_d <= VsEnd)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign x           = h_q;
  assign y           = v_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
